// File: rtl/fx2ft_sched.sv
// fx2ft_sched: schedules N_REQ requesters onto one shared converter from signed
// Q1.22 fixed point to IEEE-754 single precision.
// Two-stage pipeline: S1 holds the captured operand and its tag; S2 drives out_*.
// Configuration macro FX2FT_ROUND_ROBIN_EN: when defined, a rotating priority
// pointer is used; when undefined, fixed priority applies and the lowest index wins.
module fx2ft_sched #(
    parameter int N_REQ = 4,
    parameter int TAG_W = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [24*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_data,
    output logic [TAG_W-1:0]      out_tag
);

    logic              adv;
    logic              found;
    logic [TAG_W-1:0]  win;
    logic [TAG_W-1:0]  idx;
    logic [23:0]       win_data;

    logic              s1_valid;
    logic [23:0]       s1_data;
    logic [TAG_W-1:0]  s1_tag;

    logic              sign;
    logic [22:0]       mag;
    logic [4:0]        lead;
    logic [7:0]        expo;
    logic [22:0]       mant;
    logic [31:0]       conv;

`ifdef FX2FT_ROUND_ROBIN_EN
    logic [TAG_W-1:0]  ptr;
`endif

    // The whole pipe moves together unless a valid result is blocked at the output.
    assign adv = !out_valid || out_ready;

    // Grant search: first valid requester at or after the priority origin, wrapping.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        win_data = '0;
        idx      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
`ifdef FX2FT_ROUND_ROBIN_EN
            idx = TAG_W'((32'(ptr) + k) % N_REQ);
`else
            idx = TAG_W'(k);
`endif
            if (!found && req_valid[idx]) begin
                found    = 1'b1;
                win      = idx;
                win_data = req_data[24*idx +: 24];
            end
        end
    end

    // Ready goes only to the winner, only when S1 can load, and never during reset.
    always_comb begin
        req_ready = '0;
        if (adv && found && rst_n) begin
            req_ready[win] = 1'b1;
        end
    end

`ifdef FX2FT_ROUND_ROBIN_EN
    // Priority pointer moves to the requester just after the one that handshook.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (adv && found) begin
            ptr <= (win == TAG_W'(N_REQ - 1)) ? '0 : win + TAG_W'(1);
        end
    end
`endif

    // S1: capture the granted operand and its tag, or go empty when nobody is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_tag   <= '0;
        end else if (adv) begin
            s1_valid <= found;
            if (found) begin
                s1_data <= win_data;
                s1_tag  <= win;
            end
        end
    end

    // Converter: magnitude over 23 bits, normalise on the leading one, exact result.
    // Zero and the most-negative input have no leading one in 23 bits and are overridden.
    always_comb begin
        sign = s1_data[23];
        mag  = sign ? (~s1_data[22:0] + 23'd1) : s1_data[22:0];
        lead = '0;
        for (int unsigned b = 0; b < 23; b++) begin
            if (mag[b]) begin
                lead = 5'(b);
            end
        end
        expo = 8'd105 + {3'b000, lead};
        mant = 23'(mag << (5'd23 - lead));
        if (s1_data == 24'h000000) begin
            conv = '0;
        end else if (s1_data == 24'h800000) begin
            conv = 32'hC000_0000;
        end else begin
            conv = {sign, expo, mant};
        end
    end

    // S2: the output register, loaded from S1 whenever the pipe advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
        end else if (adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= conv;
                out_tag  <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_fx2ft_sched.sv
// tb_fx2ft_sched: randomized and directed stimulus for fx2ft_sched, checked against
// an in-order reference model (real-arithmetic float conversion, queue of in-flight items).
// Honours FX2FT_ROUND_ROBIN_EN the same way the design does.
module tb_fx2ft_sched;

    localparam int N = 4;
    localparam int TW = $clog2(N);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [24*N-1:0]   req_data = '0;
    logic [N-1:0]      req_ready;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_data;
    logic [TW-1:0]     out_tag;

    fx2ft_sched #(.N_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic [31:0] fp;
        int          prog;
    } item_t;

    item_t        q[$];
    logic [23:0]  dq[N][$];
    logic [23:0]  cur[N];
    bit           pend[N];
    int           mptr = 0;
    int           hs_idx = -1;
    int           load_pct = 0;
    int           ready_pct = 100;
    int           stall = 0;
    bit           hold_reset = 1'b1;
    bit           pulse_reset = 1'b0;
    int           n_tests = 0;
    int           n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference conversion through real arithmetic: x / 2^22, then narrow the double.
    function automatic logic [31:0] ref_fp(input logic [23:0] x);
        real         r;
        logic [63:0] d;
        int          e;
        r = real'($signed(x)) / 4194304.0;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], 8'(e), d[51:29]};
    endfunction

    function automatic logic [23:0] rand_val();
        case ($urandom_range(7))
            0: return 24'h000000;
            1: return 24'h800000;
            2: return 24'h7FFFFF;
            3: return 24'h000001;
            4: return 24'hFFFFFF;
            default: return 24'($urandom);
        endcase
    endfunction

    // Drive phase, just after the rising edge.
    task automatic drive();
        rst_n = !(hold_reset || pulse_reset);
        pulse_reset = 1'b0;
        if (hs_idx >= 0) pend[hs_idx] = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!pend[i]) begin
                if (dq[i].size() > 0) begin
                    cur[i]  = dq[i].pop_front();
                    pend[i] = 1'b1;
                end else if (int'($urandom_range(99)) < load_pct) begin
                    cur[i]  = rand_val();
                    pend[i] = 1'b1;
                end else begin
                    cur[i] = 24'($urandom);
                end
            end
            req_valid[i] = pend[i];
            req_data[24*i +: 24] = cur[i];
        end
        if (stall > 0) begin
            out_ready = 1'b0;
            stall--;
        end else begin
            out_ready = int'($urandom_range(99)) < ready_pct;
        end
    endtask

    // Observe phase, on the falling edge: predict what the next rising edge does.
    task automatic observe();
        bit          exp_valid, exp_adv;
        int          win;
        logic [N-1:0] exp_rdy;
        hs_idx = -1;
        if (!rst_n) begin
            check("rst_out_valid", 32'(out_valid), 32'h0);
            check("rst_out_data", out_data, 32'h0);
            check("rst_out_tag", 32'(out_tag), 32'h0);
            check("rst_req_ready", 32'(req_ready), 32'h0);
            q.delete();
            mptr = 0;
            return;
        end
        exp_valid = q.size() > 0 && q[0].prog == 2;
        exp_adv   = !exp_valid || out_ready;
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("out_data", out_data, q[0].fp);
            check("out_tag", 32'(out_tag), 32'(q[0].tag));
        end
        win = -1;
        if (exp_adv) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (mptr + k) % N;
                if (win < 0 && req_valid[j]) win = j;
            end
        end
        exp_rdy = '0;
        if (win >= 0) exp_rdy[win] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (exp_valid && out_ready) void'(q.pop_front());
        if (exp_adv) foreach (q[i]) q[i].prog++;
        if (win >= 0) begin
            item_t it;
            it.tag  = win;
            it.fp   = ref_fp(cur[win]);
            it.prog = 1;
            q.push_back(it);
`ifdef FX2FT_ROUND_ROBIN_EN
            mptr = (win + 1) % N;
`endif
        end
        hs_idx = win;
    endtask

    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            drive();
            @(negedge clk);
            observe();
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            cur[i]  = '0;
            pend[i] = 1'b0;
        end
        // Reset with every requester pending, then continuous contention.
        load_pct   = 100;
        ready_pct  = 100;
        hold_reset = 1'b1;
        run_cycles(3);
        hold_reset = 1'b0;
        run_cycles(20);
        load_pct = 0;
        run_cycles(6);

        // Directed values: requester 0 alone, then the value set via requester 1.
        dq[0].push_back(24'h400000);
        run_cycles(4);
        dq[1].push_back(24'h200000);
        dq[1].push_back(24'hC00000);
        dq[1].push_back(24'h000001);
        dq[1].push_back(24'h000000);
        dq[1].push_back(24'h800000);
        dq[1].push_back(24'h7FFFFF);
        run_cycles(12);

        // Backpressure: five values streamed, output stalled three cycles mid-stream.
        for (int i = 0; i < 5; i++) dq[2].push_back(rand_val());
        run_cycles(3);
        stall = 3;
        run_cycles(10);

        // Random traffic with random backpressure.
        load_pct  = 40;
        ready_pct = 70;
        run_cycles(2000);

        // Reset pulse with the pipe full, then resume.
        load_pct  = 100;
        ready_pct = 100;
        run_cycles(5);
        pulse_reset = 1'b1;
        run_cycles(8);
        load_pct  = 30;
        ready_pct = 50;
        run_cycles(300);

        // Drain.
        load_pct  = 0;
        ready_pct = 100;
        run_cycles(12);
        check("drained", 32'(q.size()), 32'h0);
        check("idle_out_valid", 32'(out_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fx2ft_sched.md
# fx2ft_sched

Round-robin scheduler sharing one 24-bit fixed-point to IEEE-754 single-precision conversion datapath among `N_REQ` requesters in the CORDIC IP. Each requester presents a signed Q1.22 value with valid/ready. The block grants one request per cycle, registers the value, converts it, and presents the float with the requester's index as a tag. It also corrects the two inputs the plain combinational converter gets wrong: zero and the most-negative value.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `TAG_W`, `$clog2(N_REQ)`: derived width of the tag; not overridden.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  `N_REQ`  per-requester valid.
- `req_data`  in  `24*N_REQ`  Q1.22 two's-complement operands; requester i occupies bits `[24*i+23:24*i]`.
- `req_ready`  out  `N_REQ`  per-requester ready (one-hot or zero).
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer ready.
- `out_data`  out  32  IEEE-754 single result.
- `out_tag`  out  `TAG_W`  index of the originating requester.

## Operation
- Two registered stages:
  - S1 holds the captured operand and its tag.
  - S2 holds the converted float and its tag (`out_*`).
- `adv = !out_valid || out_ready` controls whole-pipe movement.
  - When `adv` is high, S2 loads from S1 and S1 loads from the granted request (or empty).
  - When `adv` is low, both stages hold.
- Grant is combinational from `req_valid` and the priority pointer `ptr`.
  - The winner is the first asserted `req_valid` at or after `ptr`, searching upward and wrapping at `N_REQ-1` → 0.
  - `req_ready[g] = adv && winner==g && rst_n`.
  - A handshake on `g` sets `ptr = (g+1) mod N_REQ`.
  - `ptr` is unchanged when there is no handshake.
- Requesters must not make `req_valid` depend on `req_ready`.
- Once asserted, a requester holds `req_valid` and `req_data` until its handshake.
- Conversion in S1→S2:
  - Magnitude = two's-complement absolute value over 23 bits.
  - Locate the leading one at position p (22..0).
  - Exponent = `127 - (22-p)`.
  - Mantissa = magnitude shifted left so the leading one drops off, zero-filled to 23 bits.
  - Sign = bit 23.
- Special cases override the datapath result:
  - input `24'h000000` → `32'h00000000`.
  - input `24'h800000` → `32'hC0000000` (−2.0).
- Results are exact; there is no rounding, because 23 magnitude bits always fit in the mantissa.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_tag=0`, S1 empty, `ptr=0`, `req_ready=0` while `rst_n` is low.
- Latency: handshake in cycle n → `out_valid` from the rising edge ending cycle n+1, i.e. 2 edges after acceptance.
- Throughput: 1 result per cycle with `out_ready` held high.
- Backpressure:
  - While `out_valid && !out_ready`, `out_data` and `out_tag` are stable and all `req_ready` are low.
  - At most 2 results are in flight.
- Simultaneous `out_ready` and new grant in one cycle: both handshakes complete; no bubble.
- Reset asserted mid-operation: in-flight S1/S2 contents are discarded with no output, and `ptr` returns to 0.
- `req_valid` all low: S1 loads empty and bubbles propagate; `out_valid` falls after the last result is consumed.

## Configuration
- `FX2FT_ROUND_ROBIN_EN` defined:
  - Rotating-pointer arbitration as described above.
- Not defined:
  - `ptr` is removed.
  - Fixed priority applies, lowest index wins.
  - Starvation of higher indices is permitted.
  - All other behaviour is identical.

## Test plan
- Single request: requester 0 sends `24'h400000`, `out_ready=1` → after 2 edges `out_valid=1`, `out_data=32'h3F800000`, `out_tag=0`.
- Value coverage, each via requester 1:
  - `24'h200000` → `32'h3F000000`.
  - `24'hC00000` → `32'hBF800000`.
  - `24'h000001` → `32'h34800000`.
  - `24'h000000` → `32'h00000000`.
  - `24'h800000` → `32'hC0000000`.
- Contention with round robin: all 4 requesters valid continuously, `out_ready=1` → `out_tag` sequence 0,1,2,3,0,… with one result per cycle.
- Contention without the macro: same stimulus → `out_tag` stays 0 while requester 0 is valid.
- Backpressure: stream 5 values, drop `out_ready` for 3 cycles mid-stream → `out_data` stable while stalled, no `req_ready` asserted, all 5 results delivered in order with no loss or duplication.
- Reset mid-flight: 2 results in flight, pulse `rst_n` low for 1 cycle → `out_valid=0` immediately; the next accepted request gets its result 2 edges later with tag from `ptr=0`.
